// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and transmitter FSM states.
// Constant-only package; no latency or flow control of its own.
package uart_pkg;

  localparam int UART_DATA_BITS = 7;
  localparam int UART_STOP_BITS = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    PARITY = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/transmitter.sv
// Serial transmitter: start, even parity, data MSB first, stop; one bit per tx_en strobe.
// Load latency one tx_clk; backpressure via registered ready, one-entry holding register.
module transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 tx_start,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 tx
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic             SCNT_LAST = 1'(STOP_BITS - 1);

  tx_state_t            state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 ready_q, ready_d;
  logic [DATA_BITS-1:0] hold_dat_q, hold_dat_d;
  logic                 hold_par_q, hold_par_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 scnt_q, scnt_d;
  logic                 accept;
  logic                 load;

  assign ready  = ready_q;
  assign done   = done_q;
  assign tx     = tx_q;
  // ready_q low means the holding register carries a payload
  assign busy   = (state_q != IDLE) || !ready_q;
  assign accept = tx_start && ready_q;

  always_ff @(posedge tx_clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      hold_dat_q <= '0;
      hold_par_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      cnt_q      <= '0;
      scnt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      hold_dat_q <= hold_dat_d;
      hold_par_q <= hold_par_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      cnt_q      <= cnt_d;
      scnt_q     <= scnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    ready_d    = ready_q;
    hold_dat_d = hold_dat_q;
    hold_par_d = hold_par_q;
    shift_d    = shift_q;
    par_d      = par_q;
    cnt_d      = cnt_q;
    scnt_d     = scnt_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (tx_en && !ready_q) load = 1'b1;
      end
      START: begin
        if (tx_en) begin
          state_d = PARITY;
          tx_d    = par_q;
        end
      end
      PARITY: begin
        if (tx_en) begin
          state_d = DATA;
          tx_d    = shift_q[DATA_BITS-1];
          shift_d = shift_q << 1;
          cnt_d   = CNT_LAST;
        end
      end
      DATA: begin
        if (tx_en) begin
          // MSB of the shifter is always the next bit to send
          if (cnt_q != '0) begin
            tx_d    = shift_q[DATA_BITS-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - 1'b1;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            scnt_d  = SCNT_LAST;
          end
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tx_en) begin
          if (scnt_q != 1'b0) begin
            scnt_d = scnt_q - 1'b1;
          end else begin
            done_d = 1'b1;
            if (!ready_q) load = 1'b1;
            else          state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        scnt_d  = 1'b0;
      end
    endcase

    // Launch a pending payload; frees the holding register in the same edge
    if (load) begin
      state_d = START;
      tx_d    = 1'b0;
      shift_d = hold_dat_q;
      par_d   = hold_par_q;
      ready_d = 1'b1;
    end

    // accept and load never coincide: load needs ready_q low, accept needs it high
    if (accept) begin
      hold_dat_d = data_in;
      hold_par_d = ^data_in;
      ready_d    = 1'b0;
    end
  end

endmodule

// File: tb/tb_transmitter.sv
// Bench for transmitter: directed frames plus random traffic against a bit-queue line model.
module tb_transmitter;
  import uart_pkg::*;

  localparam int DB = UART_DATA_BITS;
  localparam int SB = UART_STOP_BITS;

  logic          tx_clk = 1'b0;
  logic          reset = 1'b0;
  logic          tx_en = 1'b0;
  logic          tx_start = 1'b0;
  logic [DB-1:0] data_in = '0;
  logic          ready, busy, done, tx;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // line model: bits still to be driven for the current frame, plus holding slot
  bit            q[$];
  logic          m_active = 1'b0;
  logic          m_hold_full = 1'b0;
  logic [DB-1:0] m_hold_dat = '0;
  logic          m_tx = 1'b1;
  logic          m_done = 1'b0;
  int            m_done_cnt = 0;
  int            dut_done_cnt = 0;
  logic [9:0]    seq = '0;

  transmitter #(.DATA_BITS(DB), .STOP_BITS(SB)) dut (
    .tx_clk   (tx_clk),
    .reset    (reset),
    .tx_en    (tx_en),
    .data_in  (data_in),
    .tx_start (tx_start),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .tx       (tx)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge(input logic en, input logic st, input logic [DB-1:0] d, input logic rst);
    logic acc;
    if (rst) begin
      q.delete();
      m_active    = 1'b0;
      m_hold_full = 1'b0;
      m_tx        = 1'b1;
      m_done      = 1'b0;
    end else begin
      acc    = st && !m_hold_full;
      m_done = 1'b0;
      if (en) begin
        if (q.size() == 0) begin
          if (m_active) begin
            m_done   = 1'b1;
            m_active = 1'b0;
            m_done_cnt++;
          end
          if (m_hold_full) begin
            q.push_back(1'b0);
            q.push_back(^m_hold_dat);
            for (int i = DB - 1; i >= 0; i--) q.push_back(m_hold_dat[i]);
            for (int i = 0; i < SB; i++) q.push_back(1'b1);
            m_hold_full = 1'b0;
            m_active    = 1'b1;
          end
        end
        if (q.size() != 0) m_tx = q.pop_front();
        else               m_tx = 1'b1;
      end
      if (acc) begin
        m_hold_full = 1'b1;
        m_hold_dat  = d;
      end
    end
  endtask

  task automatic step(input logic en, input logic st, input logic [DB-1:0] d, input logic rst);
    reset    = rst;
    tx_en    = en;
    tx_start = st;
    data_in  = d;
    @(posedge tx_clk);
    model_edge(en, st, d, rst);
    #1;
    cyc++;
    if (done === 1'b1) dut_done_cnt++;
    if (en && !rst) seq = {seq[8:0], tx};
    chk("tx",    32'(tx),    32'(m_tx));
    chk("done",  32'(done),  32'(m_done));
    chk("ready", 32'(ready), 32'(!m_hold_full));
    chk("busy",  32'(busy),  32'(m_active || m_hold_full));
  endtask

  task automatic period(input int gap);
    step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 1; i < gap; i++) step(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [9:0] exp55;
    logic [9:0] exp01;
    int frames;
    int guard;
    exp55 = 10'b0010101011;
    exp01 = 10'b0100000011;

    // reset, with tx_start and tx_en asserted to prove reset priority
    reset = 1'b1;
    step(1'b1, 1'b1, 7'h33, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // payload loaded but no strobe: line stays idle, busy stays high
    step(1'b0, 1'b1, 7'h55, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0);

    // 0x55 frame, strobe every 4th cycle; 11th strobe ends the stop bit
    seq = '0;
    for (int i = 0; i < 10; i++) period(4);
    chk("frame_55", 32'(seq), 32'(exp55));
    period(4);
    period(4);

    // 0x01 frame, odd parity bit
    step(1'b0, 1'b1, 7'h01, 1'b0);
    seq = '0;
    for (int i = 0; i < 10; i++) period(4);
    chk("frame_01", 32'(seq), 32'(exp01));
    period(4);

    // back-to-back: second payload mid-frame, third ignored while holding is full
    step(1'b0, 1'b1, 7'h55, 1'b0);
    period(4);
    step(1'b0, 1'b1, 7'h2A, 1'b0);
    step(1'b0, 1'b1, 7'h11, 1'b0);
    for (int i = 0; i < 23; i++) period(4);

    // reset during data bit 3, with a payload pending
    step(1'b0, 1'b1, 7'h3C, 1'b0);
    for (int i = 0; i < 6; i++) period(4);
    step(1'b0, 1'b1, 7'h12, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) period(3);

    // random traffic: random strobes and load requests until 100 frames complete
    frames = m_done_cnt;
    guard  = 0;
    while ((m_done_cnt - frames) < 100 && guard < 20000) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), DB'($urandom), 1'b0);
      guard++;
    end
    chk("rand_frames_done", 32'((m_done_cnt - frames) >= 100), 32'd1);
    for (int i = 0; i < 12; i++) period(2);
    chk("done_pulse_count", 32'(dut_done_cnt), 32'(m_done_cnt));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/transmitter.md
TRANSMITTER -- requirements
Module: transmitter

Interface
REQ-001 SHALL have parameter: DATA_BITS, 7, payload width, sent MSB first.
REQ-002 SHALL have parameter: STOP_BITS, 1, number of idle-high stop periods per frame (1 or 2).
REQ-003 SHALL have port: tx_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: tx_en  input  1  bit-rate strobe; the FSM advances only on tx_clk cycles with tx_en=1.
REQ-006 SHALL have port: data_in  input  DATA_BITS  payload, sampled on an accepted tx_start.
REQ-007 SHALL have port: tx_start  input  1  load request, accepted when tx_start=1 and ready=1.
REQ-008 SHALL have port: ready  output  1  holding register empty; a new payload can be accepted.
REQ-009 SHALL have port: busy  output  1  high while a frame is on the line or a payload is pending.
REQ-010 SHALL have port: done  output  1  one-tx_clk pulse as the final stop period ends.
REQ-011 SHALL have port: tx  output  1  registered serial line; idle high.

Function
REQ-012 Frame on tx SHALL be: start(0), parity, data_in[DATA_BITS-1] down to data_in[0], then STOP_BITS ones; each bit lasts exactly one tx_en period.
REQ-013 Parity bit SHALL equal XOR of the DATA_BITS payload bits (even parity over parity+data).
REQ-014 An accepted tx_start SHALL capture data_in and its parity into a one-entry holding register and clear ready on the next edge, on any tx_clk cycle regardless of tx_en.
REQ-015 tx_start while ready=0 SHALL be ignored; data_in is not captured and no state changes.
REQ-016 FSM states SHALL be IDLE, START, PARITY, DATA, STOP.
REQ-017 IDLE + tx_en + pending payload: state<=START, tx<=0, payload moves into the shift register, and ready<=1. With no tx_en, IDLE holds and tx stays 1.
REQ-018 START + tx_en: state<=PARITY, tx<=parity.
REQ-019 PARITY + tx_en: state<=DATA, tx<=MSB, bit counter<=DATA_BITS-1.
REQ-020 DATA + tx_en: if counter>0, shift the next lower bit onto tx and decrement; if counter=0, state<=STOP, tx<=1, stop counter<=STOP_BITS-1.
REQ-021 STOP + tx_en with stop counter=0: done<=1 for one cycle; if a payload is pending, go straight to START with tx<=0 (back-to-back, no idle gap); otherwise go to IDLE.
REQ-022 Frame length SHALL be 2+DATA_BITS+STOP_BITS tx_en periods, from the START launch to the next possible START.
REQ-023 ready SHALL be registered: it is 0 during the cycle a pending payload is consumed, so no tx_start can be accepted in that cycle.
REQ-024 A payload accepted mid-frame SHALL NOT disturb the frame in flight.
REQ-025 busy SHALL equal (state!=IDLE) OR (holding register full); done SHALL be 0 except for the REQ-021 pulse.
REQ-026 Counters SHALL saturate within their declared range and never wrap into an undefined state; unreachable states SHALL recover to IDLE with tx=1.

Reset
REQ-027 On reset=1 at an edge: state=IDLE, tx=1, ready=1, busy=0, done=0, holding register empty, counters 0. Reset SHALL take priority over tx_en and tx_start.
REQ-028 Reset mid-frame SHALL abort the frame: tx=1 from the next edge, and the pending payload is discarded.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum and the default DATA_BITS/STOP_BITS constants shared with the receiver.
REQ-030 The block SHALL be a single module with no sub-modules; parity SHALL be computed inline at load.

Verification
REQ-031 tx_start with data_in=7'h55, tx_en every 4th cycle -> tx per period = 0,0,1,0,1,0,1,0,1,1; done pulses once; busy low afterward.
REQ-032 data_in=7'h01 -> tx = 0,1,0,0,0,0,0,0,1,1 (parity 1).
REQ-033 Load 7'h55, then 7'h2A during the frame -> second frame starts the period after the stop bit with no idle gap; third tx_start while ready=0 is ignored.
REQ-034 Reset asserted during the DATA bit 3 period -> tx=1 and ready=1 the next edge; no done pulse.
REQ-035 Loopback into the team receiver on a shared strobe for 100 random payloads -> receiver error=0 and received bits equal {parity,payload} every frame.
REQ-036 tx_en held 0 after tx_start -> tx stays 1 and busy=1 indefinitely; the first tx_en launches START.
